// File: rtl/adc_conv_sequencer_pkg.sv
// Shared types and default constants for the ADC conversion sequencer.
`timescale 1ns/1ps
package adc_conv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } seq_state_e;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Limit the requested averaging exponent to what the accumulator supports.
    function automatic logic [2:0] clamp_log2(input logic [2:0] req, input logic [2:0] max_v);
        clamp_log2 = (req > max_v) ? max_v : req;
    endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Free-running down-counter producing a one-cycle trigger every max(period,1) cycles.
`timescale 1ns/1ps
import adc_conv_sequencer_pkg::*;

module adc_period_timer #(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk_adc,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    trigger_o
);

    logic [PERIOD_WIDTH-1:0] count_q;
    logic [PERIOD_WIDTH-1:0] count_d;
    logic [PERIOD_WIDTH-1:0] reload_s;
    logic                    trigger_q;
    logic                    trigger_d;

    // Next count and trigger; trigger is registered so it coincides with count_q == 0.
    always_comb begin
        count_d   = reload_s;
        trigger_d = 1'b0;
        if (period_i == {PERIOD_WIDTH{1'b0}}) begin
            reload_s = {PERIOD_WIDTH{1'b0}};
        end else begin
            reload_s = period_i - {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
        end
        if (enable_i) begin
            if (count_q == {PERIOD_WIDTH{1'b0}}) begin
                count_d = reload_s;
            end else begin
                count_d = count_q - {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
            end
            trigger_d = (count_d == {PERIOD_WIDTH{1'b0}});
        end else begin
            count_d   = reload_s;
            trigger_d = 1'b0;
        end
    end

    // Count and trigger registers.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            count_q   <= reload_s;
            trigger_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            trigger_q <= trigger_d;
        end
    end

    assign trigger_o = trigger_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: triggers bursts of 2^N conversions and averages the samples.
`timescale 1ns/1ps
import adc_conv_sequencer_pkg::*;

module adc_conv_sequencer #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PERIOD_WIDTH = 16,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int AVG_MAX_LOG2 = 4
) (
    input  logic                    clk_adc,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    single_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic [2:0]              avg_log2_i,
    input  logic                    clear_i,
    output logic                    conv_start_o,
    input  logic [DATA_WIDTH-1:0]   adc_data_i,
    input  logic                    adc_valid_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic                    timeout_o
);

    localparam int AW = DATA_WIDTH + AVG_MAX_LOG2;
    localparam int CW = AVG_MAX_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]    AVG_MAX_L = 3'(AVG_MAX_LOG2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    seq_state_e              state_q, state_d;
    logic [2:0]              n_q, n_d;
    logic [AW-1:0]           acc_q, acc_d, acc_sum_s;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc_s;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    result_valid_q, conv_start_q, busy_q;
    logic                    overrun_q, overrun_d, timeout_q, timeout_d;
    logic                    trigger_s, go_s, overrun_set_s, timeout_set_s;

    adc_period_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk_adc   (clk_adc),
        .rst_n     (rst_n),
        .enable_i  (enable_i),
        .period_i  (period_i),
        .trigger_o (trigger_s)
    );

    // Burst FSM next-state, accumulation and sticky flag logic.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        result_d      = result_q;
        timeout_set_s = 1'b0;
        go_s          = trigger_s | single_i;
        acc_sum_s     = acc_q + AW'(adc_data_i);
        cnt_inc_s     = cnt_q + CW'(1);
        overrun_set_s = go_s && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (go_s) begin
                    state_d = ST_START;
                    n_d     = clamp_log2(avg_log2_i, AVG_MAX_L);
                    acc_d   = {AW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                tmo_d   = TW'(1);
            end
            ST_WAIT: begin
                if (adc_valid_i) begin
                    acc_d = acc_sum_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == (CW'(1) << n_q)) begin
                        state_d  = ST_OUT;
                        result_d = DATA_WIDTH'(acc_sum_s >> n_q);
                    end else begin
                        state_d = ST_START;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    // Sample never came back: abandon the whole burst.
                    timeout_set_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_OUT: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        overrun_d = overrun_set_s ? 1'b1 : (clear_i ? 1'b0 : overrun_q);
        timeout_d = timeout_set_s ? 1'b1 : (clear_i ? 1'b0 : timeout_q);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            n_q            <= 3'd0;
            acc_q          <= {AW{1'b0}};
            cnt_q          <= {CW{1'b0}};
            tmo_q          <= {TW{1'b0}};
            result_q       <= {DATA_WIDTH{1'b0}};
            result_valid_q <= 1'b0;
            conv_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            result_q       <= result_d;
            result_valid_q <= (state_d == ST_OUT);
            conv_start_q   <= (state_d == ST_START);
            busy_q         <= (state_d != ST_IDLE);
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign conv_start_o   = conv_start_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Scoreboard bench for adc_conv_sequencer: an ADC responder model feeds samples and
// expected averages are queued at stimulus time and compared on each result handshake.
`timescale 1ns/1ps

module tb_adc_conv_sequencer;

    localparam int DW  = 16;
    localparam int PW  = 16;
    localparam int TMO = 16;

    logic          clk_adc = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          single_i;
    logic [PW-1:0] period_i;
    logic [2:0]    avg_log2_i;
    logic          clear_i;
    logic          conv_start_o;
    logic [DW-1:0] adc_data_i = 16'd0;
    logic          adc_valid_i = 1'b0;
    logic [DW-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          busy_o;
    logic          overrun_o;
    logic          timeout_o;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] smp_q[$];
    bit            adc_en    = 1'b0;
    int            adc_lat   = 1;
    bit            stray_req = 1'b0;
    bit            gap_chk   = 1'b0;
    int            pend       = -1;
    int            n_starts   = 0;
    int            last_start = -1;
    int            cyc        = 0;

    adc_conv_sequencer #(
        .DATA_WIDTH   (DW),
        .PERIOD_WIDTH (PW),
        .TIMEOUT_CYC  (TMO),
        .AVG_MAX_LOG2 (4)
    ) dut (
        .clk_adc        (clk_adc),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .single_i       (single_i),
        .period_i       (period_i),
        .avg_log2_i     (avg_log2_i),
        .clear_i        (clear_i),
        .conv_start_o   (conv_start_o),
        .adc_data_i     (adc_data_i),
        .adc_valid_i    (adc_valid_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_adc = ~clk_adc;

    always @(posedge clk_adc) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // ADC responder, start counter and result scoreboard, all just after the falling edge.
    always @(negedge clk_adc) begin
        #1;
        adc_valid_i = 1'b0;
        if (pend == 0) begin
            adc_valid_i = 1'b1;
            adc_data_i  = (smp_q.size() > 0) ? smp_q.pop_front() : 16'd0;
            pend        = -1;
        end else if (pend > 0) begin
            pend--;
        end
        if (stray_req) begin
            adc_valid_i = 1'b1;
            adc_data_i  = 16'hAAAA;
        end
        if (conv_start_o) begin
            n_starts++;
            if (gap_chk && last_start >= 0) chk("start_gap", cyc - last_start, 50);
            last_start = gap_chk ? cyc : -1;
            if (adc_en) pend = adc_lat - 1;
        end
        if (result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) chk("result_unexpected", {31'd0, result_valid_o}, 32'd0);
            else chk("result", {16'd0, result_o}, {16'd0, exp_q.pop_front()});
        end
    end

    task automatic pulse_single();
        single_i = 1'b1;
        @(negedge clk_adc);
        single_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(negedge clk_adc);
        clear_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk_adc);
            n++;
        end
        chk("idle_in_budget", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!conv_start_o && n < budget) begin
            @(negedge clk_adc);
            n++;
        end
        chk("start_in_budget", {31'd0, conv_start_o}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_conv_start"}, {31'd0, conv_start_o}, 32'd0);
        chk({tag, "_result"}, {16'd0, result_o}, 32'd0);
        chk({tag, "_result_valid"}, {31'd0, result_valid_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int base;
        int trg;
        rst_n = 1'b0; enable_i = 1'b0; single_i = 1'b0; period_i = 16'd50;
        avg_log2_i = 3'd0; clear_i = 1'b0; result_ready_i = 1'b1;
        repeat (3) @(negedge clk_adc);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk_adc);

        // Single burst of four samples averaged to 101.
        avg_log2_i = 3'd2; adc_en = 1'b1; adc_lat = 2;
        for (int i = 0; i < 4; i++) smp_q.push_back(16'(100 + i));
        exp_q.push_back(16'd101);
        base = n_starts;
        pulse_single();
        wait_idle(200);
        chk("burst_starts", n_starts - base, 4);

        // Periodic single-sample conversions every 50 cycles.
        period_i = 16'd50; avg_log2_i = 3'd0; adc_lat = 3;
        smp_q.push_back(16'd7);     exp_q.push_back(16'd7);
        smp_q.push_back(16'd500);   exp_q.push_back(16'd500);
        smp_q.push_back(16'hBEEF);  exp_q.push_back(16'hBEEF);
        smp_q.push_back(16'd12);    exp_q.push_back(16'd12);
        @(negedge clk_adc);
        base = n_starts; gap_chk = 1'b1; enable_i = 1'b1;
        repeat (220) @(negedge clk_adc);
        enable_i = 1'b0; gap_chk = 1'b0;
        wait_idle(100);
        chk("periodic_starts", n_starts - base, 4);

        // Timeout: no sample returned.
        adc_en = 1'b0; avg_log2_i = 3'd0;
        pulse_single();
        wait_start(10);
        repeat (15) @(negedge clk_adc);
        chk("timeout_early", {31'd0, timeout_o}, 32'd0);
        @(negedge clk_adc);
        chk("timeout_set", {31'd0, timeout_o}, 32'd1);
        chk("timeout_busy", {31'd0, busy_o}, 32'd0);
        chk("timeout_no_valid", {31'd0, result_valid_o}, 32'd0);
        pulse_clear();
        chk("timeout_clear", {31'd0, timeout_o}, 32'd0);

        // Overrun while result is held unaccepted.
        period_i = 16'd10; adc_en = 1'b1; adc_lat = 1; result_ready_i = 1'b0;
        smp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
        @(negedge clk_adc);
        enable_i = 1'b1;
        for (int n = 0; n < 100 && !result_valid_o; n++) @(negedge clk_adc);
        chk("ovr_valid", {31'd0, result_valid_o}, 32'd1);
        repeat (30) @(negedge clk_adc);
        chk("ovr_hold_data", {16'd0, result_o}, 32'h1234);
        chk("ovr_hold_valid", {31'd0, result_valid_o}, 32'd1);
        chk("ovr_flag", {31'd0, overrun_o}, 32'd1);
        enable_i = 1'b0; result_ready_i = 1'b1;
        @(negedge clk_adc);
        wait_idle(10);
        pulse_clear();
        chk("ovr_clear", {31'd0, overrun_o}, 32'd0);

        // Stray sample while idle must be ignored.
        stray_req = 1'b1;
        @(negedge clk_adc);
        stray_req = 1'b0;
        repeat (2) @(negedge clk_adc);
        chk("stray_busy", {31'd0, busy_o}, 32'd0);
        chk("stray_valid", {31'd0, result_valid_o}, 32'd0);

        // Clamped averaging exponent: 7 behaves as 4.
        avg_log2_i = 3'd7; adc_lat = 1;
        for (int i = 0; i < 16; i++) smp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFFFF);
        base = n_starts;
        pulse_single();
        wait_idle(300);
        chk("clamp_starts", n_starts - base, 16);

        // Period 0: trigger every cycle; the burst times out and triggers overrun.
        adc_en = 1'b0; avg_log2_i = 3'd0; period_i = 16'd0;
        @(negedge clk_adc);
        enable_i = 1'b1;
        trg = 0;
        repeat (10) begin
            @(negedge clk_adc);
            if (dut.u_timer.trigger_o) trg++;
        end
        chk("p0_triggers", trg, 10);
        enable_i = 1'b0;
        @(negedge clk_adc);
        wait_idle(40);
        chk("p0_overrun", {31'd0, overrun_o}, 32'd1);
        chk("p0_timeout", {31'd0, timeout_o}, 32'd1);
        pulse_clear();
        chk("p0_clear_ovr", {31'd0, overrun_o}, 32'd0);
        chk("p0_clear_tmo", {31'd0, timeout_o}, 32'd0);

        // Reset in the middle of WAIT.
        pulse_single();
        wait_start(10);
        repeat (3) @(negedge clk_adc);
        chk("wait_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk_adc);
        chk_all_zero("rst_wait");
        rst_n = 1'b1;
        repeat (3) @(negedge clk_adc);
        chk("rst_wait_idle", {31'd0, busy_o}, 32'd0);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
